// File: rtl/demux_pkg.sv
// Shared definitions for the TDM demultiplexer.
//   HUNT   : searching for a frame_sync beat
//   LOCKED : aligned to the frame, capturing slots
package demux_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - synchronous active-low reset (slot -> 0)
//   advance  - step slot by one, wrapping 3 -> 0
//   load_one - force slot to 1 (a sync beat was just taken as slot 0)
//   clear    - force slot to 0
//   slot     - registered slot index
// Priority: reset_n, clear, load_one, advance.
module tdm_slot_counter
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              load_one,
    input  logic              clear,
    output logic [SLOT_W-1:0] slot
);

    logic [SLOT_W-1:0] slot_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else if (clear) begin
            slot_q <= '0;
        end else if (load_one) begin
            slot_q <= SLOT_W'(1);
        end else if (advance) begin
            // NUM_SLOTS == 2**SLOT_W, so natural overflow is the modulo wrap
            slot_q <= slot_q + SLOT_W'(1);
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demultiplexer.sv
// Four-slot TDM demultiplexer. Serial beats (in_valid/in_bit) are aligned by
// frame_sync and presented as a registered parallel frame on out0..out3.
// Ports:
//   clk, reset_n           - clock, synchronous active-low reset
//   in_valid               - beat strobe
//   in_bit                 - serial data bit of the current beat
//   frame_sync             - marks the beat carrying slot 0
//   out0..out3             - last complete frame, slot n on outn
//   address0, address1     - expected slot index = 2*address0 + address1
//   frame_done             - one-cycle pulse when a new frame is loaded
//   locked                 - high while aligned to the frame
//   sync_error             - one-cycle pulse on a framing violation
//   error_count            - saturating count of sync_error pulses
module tdm_demultiplexer
    import demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 frame_sync,
    output logic                 out0,
    output logic                 out1,
    output logic                 out2,
    output logic                 out3,
    output logic                 address0,
    output logic                 address1,
    output logic                 frame_done,
    output logic                 locked,
    output logic                 sync_error,
    output logic [ERR_CNT_W-1:0] error_count
);

    state_e                 state_q;
    logic [NUM_SLOTS-2:0]   shadow_q;   // slots 0..2; slot 3 goes straight to the outputs
    logic [NUM_SLOTS-1:0]   out_q;
    logic                   frame_done_q;
    logic                   sync_error_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [SLOT_W-1:0]      slot;

    // Beat decode
    logic advance, load_one, clear;
    logic go_lock, go_hunt, realign, capture, frame_evt, err_evt;

    always_comb begin
        advance   = 1'b0;
        load_one  = 1'b0;
        clear     = 1'b0;
        go_lock   = 1'b0;
        go_hunt   = 1'b0;
        realign   = 1'b0;
        capture   = 1'b0;
        frame_evt = 1'b0;
        err_evt   = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        go_lock  = 1'b1;
                        load_one = 1'b1;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot != '0)) begin
                        // Early sync: restart the frame on this beat
                        err_evt  = 1'b1;
                        realign  = 1'b1;
                        load_one = 1'b1;
                    end else if (!frame_sync && (slot == '0)) begin
                        // Missing sync: alignment lost, drop the beat
                        err_evt = 1'b1;
                        go_hunt = 1'b1;
                        clear   = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        advance   = 1'b1;
                        frame_evt = (slot == SLOT_W'(NUM_SLOTS - 1));
                    end
                end
                default: ;
            endcase
        end
    end

    tdm_slot_counter u_slot_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .advance  (advance),
        .load_one (load_one),
        .clear    (clear),
        .slot     (slot)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
            sync_error_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            frame_done_q <= frame_evt;
            sync_error_q <= err_evt;

            if (err_evt && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end

            if (go_lock) begin
                state_q <= LOCKED;
            end else if (go_hunt) begin
                state_q <= HUNT;
            end

            // A new slot 0 invalidates any earlier partial shadows
            if (go_lock || realign) begin
                shadow_q <= {{(NUM_SLOTS - 2){1'b0}}, in_bit};
            end else if (capture && !frame_evt) begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                    if (slot == SLOT_W'(i)) begin
                        shadow_q[i] <= in_bit;
                    end
                end
            end

            if (frame_evt) begin
                out_q <= {in_bit, shadow_q};
            end
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign address0    = slot[1];
    assign address1    = slot[0];
    assign locked      = (state_q == LOCKED);
    assign frame_done  = frame_done_q;
    assign sync_error  = sync_error_q;
    assign error_count = err_cnt_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer: directed frames followed by random
// beats, checked against a slot-level reference model.
module tb_tdm_demultiplexer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       frame_sync = 1'b0;
    logic       out0, out1, out2, out3;
    logic       address0, address1;
    logic       frame_done, locked, sync_error;
    logic [7:0] error_count;

    tdm_demultiplexer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .frame_sync  (frame_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .address0    (address0),
        .address1    (address1),
        .frame_done  (frame_done),
        .locked      (locked),
        .sync_error  (sync_error),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit       m_locked = 0;
    int       m_slot   = 0;
    int       m_err    = 0;
    bit [3:0] m_out    = '0;
    bit       m_part[4];
    bit [3:0] frame_q[$];
    int       err_q[$];
    bit       started = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            started  = 1;
            m_locked = 0;
            m_slot   = 0;
            m_err    = 0;
            m_out    = '0;
            foreach (m_part[i]) m_part[i] = 0;
        end else if (in_valid) begin
            if (!m_locked) begin
                if (frame_sync) begin
                    m_locked  = 1;
                    m_part[0] = in_bit;
                    m_slot    = 1;
                end
            end else if (frame_sync && m_slot != 0) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
                err_q.push_back(m_err);
                m_part[0] = in_bit;
                m_slot    = 1;
            end else if (!frame_sync && m_slot == 0) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
                err_q.push_back(m_err);
                m_locked = 0;
            end else begin
                m_part[m_slot] = in_bit;
                if (m_slot == 3) begin
                    m_out = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    frame_q.push_back(m_out);
                end
                m_slot = (m_slot + 1) % 4;
            end
        end
    end

    // ---------------- monitor ----------------
    int n_frames = 0;
    int n_errs   = 0;

    always @(negedge clk) begin
        if (started) begin
            check("locked", int'(locked), int'(m_locked));
            check("address", int'({address0, address1}), m_slot);
            check("outputs_hold", int'({out3, out2, out1, out0}), int'(m_out));
            check("error_count", int'(error_count), m_err);
            if (frame_done) begin
                n_frames++;
                if (frame_q.size() == 0) check("frame_done_spurious", 1, 0);
                else check("frame", int'({out3, out2, out1, out0}), int'(frame_q.pop_front()));
            end else if (frame_q.size() != 0) begin
                check("frame_done_missing", 0, 1);
                void'(frame_q.pop_front());
            end
            if (sync_error) begin
                n_errs++;
                if (err_q.size() == 0) check("sync_error_spurious", 1, 0);
                else check("sync_error_count", int'(error_count), err_q.pop_front());
            end else if (err_q.size() != 0) begin
                check("sync_error_missing", 0, 1);
                void'(err_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input bit s, input bit b);
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        frame_sync = s;
        in_bit     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            frame_sync = 1'($urandom_range(0, 1));
            in_bit     = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        frame_sync = 1'b1;
        in_bit     = 1'b1;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic frame4(input bit [3:0] f);
        beat(1'b1, f[0]);
        beat(1'b0, f[1]);
        beat(1'b0, f[2]);
        beat(1'b0, f[3]);
    endtask

    int frames_before;
    int errs_before;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(1);

        // basic frame 1,0,1,1
        frames_before = n_frames;
        frame4(4'b1101);
        idle(2);
        check("basic_outs", int'({out3, out2, out1, out0}), 4'b1101);
        check("basic_locked", int'(locked), 1);
        check("basic_frame_count", n_frames - frames_before, 1);

        // same frame with a 3-cycle gap after beat 2
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        idle(3);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        idle(2);
        check("gap_outs", int'({out3, out2, out1, out0}), 4'b1101);

        // back-to-back frames
        frames_before = n_frames;
        errs_before   = n_errs;
        frame4(4'b1101);
        frame4(4'b0010);
        idle(2);
        check("b2b_outs", int'({out3, out2, out1, out0}), 4'b0010);
        check("b2b_frames", n_frames - frames_before, 2);
        check("b2b_no_errors", n_errs - errs_before, 0);

        // sync at slot 2 realigns
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        idle(2);
        check("realign_count", int'(error_count), 1);
        check("realign_outs", int'({out3, out2, out1, out0}), 4'b0110);

        // missing sync at slot 0 drops to hunt
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        idle(1);
        check("hunt_unlocked", int'(locked), 0);
        frame4(4'b1010);
        idle(1);

        // reset mid-frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        do_reset();
        check("reset_outs", int'({out3, out2, out1, out0}), 0);
        check("reset_errcnt", int'(error_count), 0);
        frame4(4'b0111);
        idle(2);

        // error counter saturation: repeated sync beats after slot 0
        repeat (302) beat(1'b1, 1'($urandom_range(0, 1)));
        idle(2);
        check("errcnt_saturated", int'(error_count), 255);

        // random traffic: mostly well-formed frames with occasional faults
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                beat(($urandom_range(0, 15) == 0) ? ~(m_slot == 0)
                                                  : (m_slot == 0),
                     1'($urandom_range(0, 1)));
            end else begin
                idle(1);
            end
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        idle(3);
        check("frames_drained", frame_q.size(), 0);
        check("errors_drained", err_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
